spi_cmd_sm: RTL
===============

Name: spi_cmd_sm

Overview:
Parametrised successor to the SPI-slave command state machine on the CycloneIII digitizer. It decodes a strobed command from the SPI front end, steers the shared SPI shift register to the register-read, register-write or FIFO-dump datapath, and counts FIFO words for packet transfers. Over the previous generation it adds:
- configurable widths and opcodes
- an explicit command strobe
- an exact N-word packet count (no off-by-one extra word)
- abort
- busy, remaining-count, packet-done and command-error status
- an optional watchdog timeout.

Parameters:
CMD_W, 4, command field width.
CNT_W, 8, packet-size and word-counter width.
OP_FIFO, 1, opcode for FIFO packet send.
OP_RD, 2, opcode for register read.
OP_WR, 3, opcode for register write.
TIMEOUT_CYC, 4096, clk cycles without a done before the watchdog fires (optional feature only; must be ≥2).

Ports:
clk  in  1  system clock
rst  in  1  reset (asynchronous, active-high)
cmd  in  CMD_W  command opcode, sampled only when cmd_valid=1
cmd_valid  in  1  one-cycle command strobe
done  in  1  one-cycle pulse: the current SPI word transfer completed
fifo_pk_sz  in  CNT_W  packet length in words, sampled with an OP_FIFO command
abort  in  1  force return to IDLE
rd_select  out  1  register-read path selected
wr_select  out  1  register-write path selected
fifo_select  out  1  FIFO-dump path selected
busy  out  1  state is not IDLE
word_cnt  out  CNT_W  words remaining in the current FIFO packet
pk_done  out  1  one-cycle pulse: FIFO packet finished normally
cmd_err  out  1  one-cycle pulse: command rejected
timeout_err  out  1  one-cycle pulse: watchdog fired

Behaviour:
- Reset is asynchronous, active-high. Mid-operation reset returns the block to IDLE immediately.
- Reset values: state=IDLE, word_cnt=0, every output 0.
- All outputs are registered. Selects and busy decode the next state, so they change on the same edge as the state register.
- One-hot states: IDLE, FIFO_SEND, RD, WR.
- IDLE, on cmd_valid=1:
  - OP_RD -> RD; rd_select=1 and busy=1 from the next edge.
  - OP_WR -> WR; wr_select=1 and busy=1 from the next edge.
  - OP_FIFO with fifo_pk_sz=N>0 -> FIFO_SEND; fifo_select=1, busy=1, word_cnt=N.
  - OP_FIFO with N=0 -> stay in IDLE; pk_done pulses on the next cycle; no select asserted.
  - Any other opcode -> stay in IDLE; cmd_err pulses.
- RD / WR: done=1 -> IDLE at the next edge; the select drops on that edge. Exactly one word per command.
- FIFO_SEND, on done=1:
  - word_cnt>1: decrement word_cnt.
  - word_cnt==1: word_cnt=0, go to IDLE, pk_done pulses.
  - Exactly N done pulses end an N-word packet.
- cmd_valid while busy is ignored. State and counter are unaffected, and cmd_err pulses.
- A command arriving in the same cycle that done ends a transfer is also rejected with cmd_err.
- abort=1 in any non-IDLE state:
  - IDLE at the next edge; all selects drop; word_cnt cleared.
  - No pk_done pulse.
  - abort takes priority over a simultaneous done or timeout.
  - abort in IDLE has no effect, including on a simultaneous cmd_valid, which is processed normally.
- word_cnt is unsigned, CNT_W wide, and never wraps: it is never decremented below 0.
- Maximum packet length is 2^CNT_W−1 words.
- At most one select is high at any time.

Optional Feature:
Macro SPI_CMD_TIMEOUT_EN.
- Defined:
  - A watchdog counter of width ceil(log2(TIMEOUT_CYC)) clears on entry to any non-IDLE state and on every done.
  - It counts every clk while busy.
  - If it reaches TIMEOUT_CYC−1 with no done that cycle, the block goes to IDLE at the next edge, clears word_cnt and drops all selects.
  - timeout_err pulses for one cycle; pk_done does not pulse.
  - done in the same cycle as expiry wins; no timeout fires.
- Undefined: no counter is built; timeout_err is tied to 0; non-IDLE states wait for done indefinitely.

Test Plan:
1. Reset, then cmd=2 with cmd_valid, then done 5 cycles later -> rd_select=1 and busy=1 from the edge after the strobe; both return to 0 on the edge after done; wr_select and fifo_select stay 0.
2. cmd=1, fifo_pk_sz=3, then 3 done pulses spaced 4 cycles apart -> word_cnt goes 3,2,1,0; fifo_select drops with the third done; one pk_done pulse; cmd_err=0.
3. cmd=1 with fifo_pk_sz=0 -> no select ever asserts, pk_done pulses once, busy stays 0. Then cmd=7 -> cmd_err pulses once, state stays IDLE.
4. In FIFO_SEND with word_cnt=2: strobe cmd=3 -> cmd_err pulses and word_cnt stays 2. Then assert abort together with done -> IDLE, word_cnt=0, no pk_done.
5. Assert rst asynchronously mid-packet (word_cnt=5) -> all outputs 0 immediately, without waiting for a clk edge. After release, cmd=3 then done -> normal WR cycle.
6. With SPI_CMD_TIMEOUT_EN and TIMEOUT_CYC=16: cmd=2 with no done -> timeout_err pulses exactly 16 cycles after entry, rd_select drops. Repeat with done at cycle 15 -> normal completion, no timeout_err.

Source files
------------

// File: rtl/spi_cmd_sm_if.sv
// -----------------------------------------------------------------------------
// spi_cmd_sm_if
// Command/status bundle between the SPI front end and the command state
// machine.
//   slave  modport (state machine side):
//     in  : cmd, cmd_valid, done, fifo_pk_sz, abort
//     out : rd_select, wr_select, fifo_select, busy, word_cnt,
//           pk_done, cmd_err, timeout_err
//   master modport (front end side): same signals, opposite directions.
// -----------------------------------------------------------------------------
interface spi_cmd_sm_if #(
   parameter int CMD_W = 4,
   parameter int CNT_W = 8
);
   logic [CMD_W-1:0] cmd;
   logic             cmd_valid;
   logic             done;
   logic [CNT_W-1:0] fifo_pk_sz;
   logic             abort;
   logic             rd_select;
   logic             wr_select;
   logic             fifo_select;
   logic             busy;
   logic [CNT_W-1:0] word_cnt;
   logic             pk_done;
   logic             cmd_err;
   logic             timeout_err;

   modport slave (
      input  cmd, cmd_valid, done, fifo_pk_sz, abort,
      output rd_select, wr_select, fifo_select, busy, word_cnt,
             pk_done, cmd_err, timeout_err
   );

   modport master (
      output cmd, cmd_valid, done, fifo_pk_sz, abort,
      input  rd_select, wr_select, fifo_select, busy, word_cnt,
             pk_done, cmd_err, timeout_err
   );
endinterface

// File: rtl/spi_cmd_sm.sv
// -----------------------------------------------------------------------------
// spi_cmd_sm
// Decodes a strobed SPI command, steers the shared shift register to the
// register-read, register-write or FIFO-dump datapath and counts FIFO words
// for packet transfers.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : spi_cmd_sm_if.slave (command inputs, selects and status outputs)
// Build option:
//   SPI_CMD_TIMEOUT_EN - when defined, a watchdog returns the block to IDLE
//   after TIMEOUT_CYC cycles in a busy state without a done.
// All outputs are registered; selects/busy decode the next state so they
// switch on the same edge as the state register.
// -----------------------------------------------------------------------------
module spi_cmd_sm #(
   parameter int CMD_W       = 4,
   parameter int CNT_W       = 8,
   parameter int OP_FIFO     = 1,
   parameter int OP_RD       = 2,
   parameter int OP_WR       = 3,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic         clk,
   input  logic         rst,
   spi_cmd_sm_if.slave  bus
);

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_FIFO = 4'b0010,
      S_RD   = 4'b0100,
      S_WR   = 4'b1000
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rd_sel_q, wr_sel_q, fifo_sel_q, busy_q;
   logic             pk_done_q, pk_done_d;
   logic             cmd_err_q, cmd_err_d;
   logic             expire;

   // The watchdog needs at least one non-zero count; smaller values leave
   // this marker block in the elaborated hierarchy as a visible flag.
   if (TIMEOUT_CYC < 2) begin : g_timeout_cyc_too_small
   end

`ifdef SPI_CMD_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            tmo_q, tmo_d;

   // done has already been excluded from expiry: a done on the last cycle wins.
   assign expire = (state_q != S_IDLE) && !bus.done &&
                   (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pk_done_d = 1'b0;
      cmd_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            // abort is meaningless here; a coincident command is handled normally
            if (bus.cmd_valid) begin
               if (bus.cmd == CMD_W'(OP_RD)) begin
                  state_d = S_RD;
               end else if (bus.cmd == CMD_W'(OP_WR)) begin
                  state_d = S_WR;
               end else if (bus.cmd == CMD_W'(OP_FIFO)) begin
                  if (bus.fifo_pk_sz != '0) begin
                     state_d = S_FIFO;
                     cnt_d   = bus.fifo_pk_sz;
                  end else begin
                     pk_done_d = 1'b1;   // empty packet completes at once
                  end
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
         end
         default: begin
            // Any strobe while busy (including on the done cycle) is rejected.
            cmd_err_d = bus.cmd_valid;
            if (bus.abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (bus.done) begin
               if (state_q == S_FIFO) begin
                  if (cnt_q > CNT_W'(1)) begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end else begin
                     cnt_d     = '0;
                     state_d   = S_IDLE;
                     pk_done_d = 1'b1;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end else if (expire) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
      endcase
   end

`ifdef SPI_CMD_TIMEOUT_EN
   always_comb begin
      tmo_d = expire && !bus.abort;
      if (state_q == S_IDLE || state_d == S_IDLE || bus.done) begin
         wd_d = '0;
      end else begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q  <= '0;
         tmo_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         tmo_q <= tmo_d;
      end
   end

   assign bus.timeout_err = tmo_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rd_sel_q   <= 1'b0;
         wr_sel_q   <= 1'b0;
         fifo_sel_q <= 1'b0;
         busy_q     <= 1'b0;
         pk_done_q  <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_sel_q   <= (state_d == S_RD);
         wr_sel_q   <= (state_d == S_WR);
         fifo_sel_q <= (state_d == S_FIFO);
         busy_q     <= (state_d != S_IDLE);
         pk_done_q  <= pk_done_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   assign bus.rd_select   = rd_sel_q;
   assign bus.wr_select   = wr_sel_q;
   assign bus.fifo_select = fifo_sel_q;
   assign bus.busy        = busy_q;
   assign bus.word_cnt    = cnt_q;
   assign bus.pk_done     = pk_done_q;
   assign bus.cmd_err     = cmd_err_q;

endmodule
